// File: rtl/sram_arbiter.sv
// Two-master round-robin arbiter onto a single-port synchronous SRAM.
// Optional grant retention (lock) is enabled by defining SRAM_ARBITER_LOCK_EN.
module sram_arbiter #(
  parameter int LEN_ADDR = 64,
  parameter int LEN_DATA = 64,
  parameter int MAX_LOCK = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic [LEN_ADDR-1:0]   m0_addr,
  input  logic [LEN_DATA-1:0]   m0_wdata,
  input  logic [LEN_DATA/8-1:0] m0_wstrb,
  input  logic                  m0_lock,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [LEN_DATA-1:0]   m0_rdata,
  input  logic                  m1_req,
  input  logic [LEN_ADDR-1:0]   m1_addr,
  input  logic [LEN_DATA-1:0]   m1_wdata,
  input  logic [LEN_DATA/8-1:0] m1_wstrb,
  input  logic                  m1_lock,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [LEN_DATA-1:0]   m1_rdata,
  output logic                  s_ena,
  output logic [LEN_ADDR-1:0]   s_addra,
  output logic [LEN_DATA-1:0]   s_dina,
  output logic [LEN_DATA/8-1:0] s_wea,
  input  logic [LEN_DATA-1:0]   s_douta
);

  localparam int LEN_STRB = LEN_DATA / 8;

  logic rr_last_q, rr_last_d;
  logic rd_pend_q, rd_pend_d;
  logic rd_tag_q, rd_tag_d;
  logic arb0, arb1;
  logic g0, g1;

`ifdef SRAM_ARBITER_LOCK_EN
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_e;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
`else
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock;
`endif

  // Tie goes to the master that did not win most recently.
  always_comb begin
    arb0 = m0_req && (!m1_req || rr_last_q);
    arb1 = m1_req && !arb0;
  end

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst_n) begin
`ifdef SRAM_ARBITER_LOCK_EN
      case (state_q)
        LOCK0:   g0 = m0_req;
        LOCK1:   g1 = m1_req;
        default: begin
          g0 = arb0;
          g1 = arb1;
        end
      endcase
`else
      g0 = arb0;
      g1 = arb1;
`endif
    end
  end

  assign m0_gnt  = g0;
  assign m1_gnt  = g1;
  assign s_ena   = g0 | g1;
  assign s_addra = g1 ? m1_addr  : m0_addr;
  assign s_dina  = g1 ? m1_wdata : m0_wdata;
  assign s_wea   = g0 ? m0_wstrb : (g1 ? m1_wstrb : {LEN_STRB{1'b0}});

  // Single outstanding read: the pending flag plus a tag naming the reader.
  assign m0_rvalid = rd_pend_q & ~rd_tag_q;
  assign m1_rvalid = rd_pend_q &  rd_tag_q;
  assign m0_rdata  = s_douta;
  assign m1_rdata  = s_douta;

  always_comb begin
    rr_last_d = rr_last_q;
    if (g0) rr_last_d = 1'b0;
    if (g1) rr_last_d = 1'b1;
    rd_pend_d = (g0 && (m0_wstrb == '0)) || (g1 && (m1_wstrb == '0));
    rd_tag_d  = g1;
`ifdef SRAM_ARBITER_LOCK_EN
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      LOCK0: begin
        if (!m0_req) begin
          state_d    = ARB;
          lock_cnt_d = '0;
          rr_last_d  = 1'b0;
        end else if (!m0_lock || lock_cnt_q >= CNT_W'(MAX_LOCK - 1)) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      LOCK1: begin
        if (!m1_req) begin
          state_d    = ARB;
          lock_cnt_d = '0;
          rr_last_d  = 1'b1;
        end else if (!m1_lock || lock_cnt_q >= CNT_W'(MAX_LOCK - 1)) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: begin
        // A single-grant limit means a lock would release immediately.
        if (MAX_LOCK > 1) begin
          if (g0 && m0_lock) begin
            state_d    = LOCK0;
            lock_cnt_d = CNT_W'(1);
          end else if (g1 && m1_lock) begin
            state_d    = LOCK1;
            lock_cnt_d = CNT_W'(1);
          end
        end
      end
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q  <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_tag_q   <= 1'b0;
`ifdef SRAM_ARBITER_LOCK_EN
      state_q    <= ARB;
      lock_cnt_q <= '0;
`endif
    end else begin
      rr_last_q  <= rr_last_d;
      rd_pend_q  <= rd_pend_d;
      rd_tag_q   <= rd_tag_d;
`ifdef SRAM_ARBITER_LOCK_EN
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

endmodule
